// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: instruction-field, status and control bundle between the multicycle control FSM and its datapath
// master : the controller (reads opcode/funct3/funct7b5/zero/mem_ready, drives selects and enables)
// slave  : the datapath/memory side (the mirror image)
// ILLEGAL_TRAP_EN adds illegal_instr, driven by the controller
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic [1:0] imm_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [1:0] result_src;
  logic       adr_src;
  logic       mem_req;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic       mem_write;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal_instr;
  modport master (
    input  opcode, funct3, funct7b5, zero, mem_ready,
    output imm_src, alu_src_a, alu_src_b, alu_control, result_src,
           adr_src, mem_req, ir_write, pc_write, reg_write, mem_write, illegal_instr
  );
  modport slave (
    output opcode, funct3, funct7b5, zero, mem_ready,
    input  imm_src, alu_src_a, alu_src_b, alu_control, result_src,
           adr_src, mem_req, ir_write, pc_write, reg_write, mem_write, illegal_instr
  );
`else
  modport master (
    input  opcode, funct3, funct7b5, zero, mem_ready,
    output imm_src, alu_src_a, alu_src_b, alu_control, result_src,
           adr_src, mem_req, ir_write, pc_write, reg_write, mem_write
  );
  modport slave (
    output opcode, funct3, funct7b5, zero, mem_ready,
    input  imm_src, alu_src_a, alu_src_b, alu_control, result_src,
           adr_src, mem_req, ir_write, pc_write, reg_write, mem_write
  );
`endif
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multicycle RV32I core (shared ALU, unified memory port, ready stall)
// clk   : rising-edge core clock
// reset : asynchronous active-high, returns to FETCH and forces every output to 0 while high
// c     : multicycle_ctrl_if.master (instruction fields, zero, mem_ready in; selects and enables out)
// ILLEGAL_TRAP_EN : unknown opcodes park in TRAP (illegal_instr high) until reset instead of acting as a NOP
module multicycle_ctrl #(
  parameter logic [3:0] RESET_STATE_ENC = 4'd0
) (
  input logic               clk,
  input logic               reset,
  multicycle_ctrl_if.master c
);
  typedef enum logic [3:0] {
    FETCH    = RESET_STATE_ENC,
    DECODE   = RESET_STATE_ENC + 4'd1,
    MEMADR   = RESET_STATE_ENC + 4'd2,
    MEMREAD  = RESET_STATE_ENC + 4'd3,
    MEMWB    = RESET_STATE_ENC + 4'd4,
    MEMWRITE = RESET_STATE_ENC + 4'd5,
    EXEC_R   = RESET_STATE_ENC + 4'd6,
    EXEC_I   = RESET_STATE_ENC + 4'd7,
    ALUWB    = RESET_STATE_ENC + 4'd8,
    BEQ      = RESET_STATE_ENC + 4'd9,
    JAL      = RESET_STATE_ENC + 4'd10,
    TRAP     = RESET_STATE_ENC + 4'd11
  } state_t;
`ifdef ILLEGAL_TRAP_EN
  localparam state_t ILL_NEXT = TRAP;
`else
  localparam state_t ILL_NEXT = FETCH;
`endif
  state_t     state;
  state_t     dec_next;
  logic       live;
  logic [2:0] alu_dec;
  always_comb begin
    dec_next = (c.opcode == 7'b0000011 || c.opcode == 7'b0100011) ? MEMADR :
               c.opcode == 7'b0110011 ? EXEC_R :
               c.opcode == 7'b0010011 ? EXEC_I :
               c.opcode == 7'b1100011 ? BEQ :
               c.opcode == 7'b1101111 ? JAL : ILL_NEXT;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= FETCH;
    else
      case (state)
        FETCH:    if (c.mem_ready) state <= DECODE;
        DECODE:   state <= dec_next;
        MEMADR:   state <= c.opcode[5] ? MEMWRITE : MEMREAD;
        MEMREAD:  if (c.mem_ready) state <= MEMWB;
        MEMWRITE: if (c.mem_ready) state <= FETCH;
        EXEC_R:   state <= ALUWB;
        EXEC_I:   state <= ALUWB;
        JAL:      state <= ALUWB;
        TRAP:     state <= TRAP;
        default:  state <= FETCH;
      endcase
  assign live = ~reset;
  // funct7b5 only selects sub for R-type; in I-type it is an immediate bit
  assign alu_dec = c.funct3 == 3'b000 ? {2'b00, (state == EXEC_R) & c.funct7b5} :
                   c.funct3 == 3'b010 ? 3'b101 :
                   c.funct3 == 3'b110 ? 3'b011 :
                   c.funct3 == 3'b111 ? 3'b010 : 3'b000;
  assign c.mem_req   = live & (state == FETCH || state == MEMREAD || state == MEMWRITE);
  assign c.ir_write  = live & (state == FETCH) & c.mem_ready;
  assign c.pc_write  = live & ((state == FETCH && c.mem_ready) || state == JAL || (state == BEQ && c.zero));
  assign c.reg_write = live & (state == MEMWB || state == ALUWB);
  assign c.mem_write = live & (state == MEMWRITE);
  assign c.adr_src   = live & (state == MEMREAD || state == MEMWRITE);
  assign c.alu_src_a = !live ? 2'b00 :
                       (state == DECODE || state == JAL) ? 2'b01 :
                       (state == MEMADR || state == EXEC_R || state == EXEC_I || state == BEQ) ? 2'b10 : 2'b00;
  assign c.alu_src_b = !live ? 2'b00 :
                       (state == FETCH || state == JAL) ? 2'b10 :
                       (state == DECODE || state == MEMADR || state == EXEC_I) ? 2'b01 : 2'b00;
  // opcode[5] separates sw (S immediate) from lw (I immediate) in MEMADR
  assign c.imm_src = !live ? 2'b00 :
                     state == DECODE ? 2'b10 :
                     state == MEMADR ? {1'b0, c.opcode[5]} : 2'b00;
  assign c.result_src = !live ? 2'b00 :
                        state == FETCH ? 2'b10 :
                        state == MEMWB ? 2'b01 : 2'b00;
  assign c.alu_control = !live ? 3'b000 :
                         state == BEQ ? 3'b001 :
                         (state == EXEC_R || state == EXEC_I) ? alu_dec : 3'b000;
`ifdef ILLEGAL_TRAP_EN
  assign c.illegal_instr = live & (state == TRAP);
`endif
endmodule
